// File: rtl/knn_pkg.sv
// Shared definitions for the KNN host sequencer: sequencer states, default
// geometry of the accelerator core and a width helper for the counters.
package knn_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_DIMENSIONS   = 32;
  localparam int DEF_NUM_CH       = 1;
  localparam int DEF_K            = 1;
  localparam int DEF_DRAIN_CYCLES = 8;
  localparam int DEF_RD_LAT       = 2;
  localparam int NAME_W           = 32;
  localparam int VEC_W            = 16;

  typedef enum logic [3:0] {
    IDLE, LOAD_Q, START, LOAD_T, DONE, DRAIN, RD_ISSUE, RD_WAIT, OUT
  } knn_state_e;

  // Never returns less than 1 so single-entry counters still get a bit.
  function automatic int knn_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/knn_read_pipe.sv
// Readback engine: issues knn_rd_en, waits out the core read latency, then
// holds each captured (name, value) pair on the result stream until taken.
module knn_read_pipe
  import knn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K          = DEF_K,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [NAME_W-1:0]     knn_name_in,
  input  logic [DATA_WIDTH-1:0] knn_value_in,
  input  logic                  m_ready,
  output logic                  knn_rd_en,
  output logic                  m_valid,
  output logic [NAME_W-1:0]     m_name,
  output logic [DATA_WIDTH-1:0] m_value,
  output logic                  done
);

  localparam int LAT_W = knn_clog2(RD_LAT);
  localparam int RES_W = knn_clog2(K + 1);

  knn_state_e       state, state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic [RES_W-1:0] res_cnt;
  logic             lat_last;
  logic             take;

  assign lat_last = (lat_cnt == LAT_W'(RD_LAT - 1));
  assign take     = (state == OUT) && m_valid && m_ready;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:     if (go) state_nxt = RD_ISSUE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (lat_last) state_nxt = OUT;
      OUT: begin
        if (take) begin
          if (res_cnt == RES_W'(K - 1)) begin
            state_nxt = IDLE;
            done      = 1'b1;
          end else begin
            state_nxt = RD_ISSUE;
          end
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      res_cnt   <= '0;
      knn_rd_en <= 1'b0;
      m_valid   <= 1'b0;
      m_name    <= '0;
      m_value   <= '0;
    end else begin
      state     <= state_nxt;
      knn_rd_en <= (state_nxt == RD_ISSUE);
      lat_cnt   <= (state == RD_WAIT) ? lat_cnt + LAT_W'(1) : '0;
      if (state == IDLE && go) res_cnt <= '0;
      else if (take)           res_cnt <= res_cnt + RES_W'(1);
      // Capture lands on the cycle the core's registered read data is valid.
      if (state == RD_WAIT && lat_last) begin
        m_valid <= 1'b1;
        m_name  <= knn_name_in;
        m_value <= knn_value_in;
      end else if (take) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/knn_host_sequencer.sv
// Host-side sequencer for the KNN core: streams query and training words in,
// strobes start/done, drains, then hands readback to knn_read_pipe.
module knn_host_sequencer
  import knn_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DIMENSIONS   = DEF_DIMENSIONS,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int K            = DEF_K,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int RD_LAT       = DEF_RD_LAT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_go,
  input  logic [VEC_W-1:0]             cmd_num_vec,
  output logic                         cmd_busy,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NAME_W-1:0]            m_name,
  output logic [DATA_WIDTH-1:0]        m_value,
  output logic                         knn_wr_en,
  output logic                         knn_rd_en,
  output logic                         knn_start,
  output logic                         knn_done,
  output logic [NUM_CH*DATA_WIDTH-1:0] knn_data,
  input  logic [NAME_W-1:0]            knn_name_in,
  input  logic [DATA_WIDTH-1:0]        knn_value_in
);

  localparam int DIM_W = knn_clog2(DIMENSIONS);
  localparam int DRN_W = knn_clog2(DRAIN_CYCLES);

  knn_state_e       state, state_nxt;
  logic [DIM_W-1:0] dim_cnt;
  logic [VEC_W-1:0] vec_cnt;
  logic [VEC_W-1:0] vec_total;
  logic [DRN_W-1:0] drn_cnt;
  logic             hs;
  logic             dim_last;
  logic             vec_last;
  logic             rd_go;
  logic             rd_done;

  assign s_ready  = (state == LOAD_Q) || (state == LOAD_T);
  assign cmd_busy = (state != IDLE);
  assign hs       = s_valid && s_ready;
  assign dim_last = (dim_cnt == DIM_W'(DIMENSIONS - 1));
  assign vec_last = ((vec_cnt + VEC_W'(1)) == vec_total);

  always_comb begin
    state_nxt = state;
    rd_go     = 1'b0;
    case (state)
      IDLE:     if (cmd_go) state_nxt = LOAD_Q;
      LOAD_Q:   if (hs && dim_last) state_nxt = START;
      START:    state_nxt = (vec_total == '0) ? DONE : LOAD_T;
      LOAD_T:   if (hs && dim_last && vec_last) state_nxt = DONE;
      DONE:     state_nxt = DRAIN;
      DRAIN:    if (drn_cnt == DRN_W'(DRAIN_CYCLES - 1)) state_nxt = RD_ISSUE;
      // Readback runs inside knn_read_pipe; RD_WAIT parks here until it reports done.
      RD_ISSUE: begin
        rd_go     = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT:  if (rd_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dim_cnt   <= '0;
      vec_cnt   <= '0;
      vec_total <= '0;
      drn_cnt   <= '0;
      knn_wr_en <= 1'b0;
      knn_start <= 1'b0;
      knn_done  <= 1'b0;
      knn_data  <= '0;
    end else begin
      state     <= state_nxt;
      knn_wr_en <= hs;
      knn_start <= (state == START);
      knn_done  <= (state == DONE);
      if (hs) knn_data <= s_data;
      if (state == IDLE) begin
        dim_cnt <= '0;
        vec_cnt <= '0;
        if (cmd_go) vec_total <= cmd_num_vec;
      end else if (hs) begin
        dim_cnt <= dim_last ? '0 : dim_cnt + DIM_W'(1);
        if (state == LOAD_T && dim_last) vec_cnt <= vec_cnt + VEC_W'(1);
      end
      drn_cnt <= (state == DRAIN) ? drn_cnt + DRN_W'(1) : '0;
    end
  end

  knn_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .K          (K),
    .RD_LAT     (RD_LAT)
  ) u_read_pipe (
    .clk          (clk),
    .reset        (reset),
    .go           (rd_go),
    .knn_name_in  (knn_name_in),
    .knn_value_in (knn_value_in),
    .m_ready      (m_ready),
    .knn_rd_en    (knn_rd_en),
    .m_valid      (m_valid),
    .m_name       (m_name),
    .m_value      (m_value),
    .done         (rd_done)
  );

endmodule

// File: tb/tb_knn_host_sequencer.sv
// Scoreboard bench for knn_host_sequencer with a small registered core model
// on the readback side (DIMENSIONS=4, K=3, DRAIN_CYCLES=8, RD_LAT=2).
module tb_knn_host_sequencer;

  localparam int DW  = 32;
  localparam int DIM = 4;
  localparam int NCH = 1;
  localparam int KR  = 3;
  localparam int DRN = 8;
  localparam int RDL = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_go = 1'b0;
  logic [15:0]       cmd_num_vec = '0;
  logic              cmd_busy;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [NCH*DW-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [31:0]       m_name;
  logic [DW-1:0]     m_value;
  logic              knn_wr_en, knn_rd_en, knn_start, knn_done;
  logic [NCH*DW-1:0] knn_data;
  logic [31:0]       knn_name_in;
  logic [DW-1:0]     knn_value_in;

  always #5 clk = ~clk;

  knn_host_sequencer #(
    .DATA_WIDTH (DW), .DIMENSIONS (DIM), .NUM_CH (NCH),
    .K (KR), .DRAIN_CYCLES (DRN), .RD_LAT (RDL)
  ) dut (
    .clk (clk), .reset (reset), .cmd_go (cmd_go), .cmd_num_vec (cmd_num_vec),
    .cmd_busy (cmd_busy), .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
    .m_valid (m_valid), .m_ready (m_ready), .m_name (m_name), .m_value (m_value),
    .knn_wr_en (knn_wr_en), .knn_rd_en (knn_rd_en), .knn_start (knn_start),
    .knn_done (knn_done), .knn_data (knn_data), .knn_name_in (knn_name_in),
    .knn_value_in (knn_value_in)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Core table: the i-th read of the run returns these.
  function automatic logic [31:0] core_name(input int i);
    return 32'd7 + 32'(16 * i);
  endfunction
  function automatic logic [31:0] core_value(input int i);
    return 32'h20 + 32'(i);
  endfunction

  // Core read model: data valid exactly RD_LAT cycles after rd_en, junk otherwise.
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [31:0] p1_n = '0, p1_d = '0, p2_n = '0, p2_d = '0;
  int          mdl_idx = 0;
  always @(posedge clk) begin
    p1_v <= knn_rd_en;
    if (knn_rd_en) begin
      p1_n    <= core_name(mdl_idx);
      p1_d    <= core_value(mdl_idx);
      mdl_idx <= mdl_idx + 1;
    end
    p2_v <= p1_v;
    p2_n <= p1_n;
    p2_d <= p1_d;
  end
  assign knn_name_in  = p2_v ? p2_n : 32'hDEAD_BEEF;
  assign knn_value_in = p2_v ? p2_d : 32'hBAD0_0BAD;

  typedef struct { logic [31:0] d; int c; } wr_t;
  typedef struct { logic [31:0] n; logic [31:0] v; } res_t;
  wr_t  wr_q[$];
  res_t res_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_total = 0, start_total = 0, done_total = 0, rd_total = 0, hs_total = 0;
  int last_wr_cyc = 0, start_cyc = 0, done_cyc = 0, last_rd_cyc = 0, last_hs_cyc = 0;
  int exp_rd_idx = 0;
  bit await_rd = 0, in_drain = 0;
  bit prev_mv = 0, prev_mr = 0, prev_busy = 0, prev_sready = 0;
  logic [31:0] prev_name = '0, prev_val = '0;

  always @(negedge clk) begin
    int   ns;
    wr_t  we;
    res_t re;
    if (!reset) begin
      wr_q.delete();
      res_q.delete();
      await_rd  = 0;
      in_drain  = 0;
      prev_mv   = 0;
      prev_mr   = 0;
      prev_busy = 0;
    end else begin
      ns = int'(knn_wr_en) + int'(knn_start) + int'(knn_done) + int'(knn_rd_en);
      if (ns != 0) check_eq("strobe_excl", ns, 1);
      if (knn_wr_en) begin
        if (wr_q.size() == 0) check_eq("wr_unexpected", 1, 0);
        else begin
          we = wr_q.pop_front();
          check_eq("wr_data", knn_data, we.d);
          check_eq("wr_cycle", cyc, we.c);
        end
        wr_total++;
        last_wr_cyc = cyc;
      end
      if (knn_start) begin
        check_eq("start_after_query", cyc - last_wr_cyc, 1);
        check_eq("s_ready_in_start", prev_sready, 0);
        start_total++;
        start_cyc = cyc;
      end
      if (knn_done) begin
        check_eq("done_lat", cyc - ((last_wr_cyc > start_cyc) ? last_wr_cyc : start_cyc), 1);
        check_eq("s_ready_in_done", prev_sready, 0);
        done_total++;
        done_cyc = cyc;
        await_rd = 1;
        in_drain = 1;
      end
      if (in_drain) check_eq("s_ready_in_drain", s_ready, 0);
      if (knn_rd_en) begin
        if (await_rd) check_eq("rd_after_done", cyc - done_cyc, DRN + 1);
        else          check_eq("rd_after_handshake", cyc - last_hs_cyc, 1);
        await_rd = 0;
        in_drain = 0;
        rd_total++;
        last_rd_cyc = cyc;
        res_q.push_back('{n: core_name(exp_rd_idx), v: core_value(exp_rd_idx)});
        exp_rd_idx++;
      end
      if (m_valid && !prev_mv) check_eq("m_valid_lat", cyc - last_rd_cyc, RDL + 1);
      if (prev_mv && !prev_mr) begin
        check_eq("m_valid_hold", m_valid, 1);
        check_eq("m_name_hold", m_name, prev_name);
        check_eq("m_value_hold", m_value, prev_val);
      end
      if (m_valid && m_ready) begin
        if (res_q.size() == 0) check_eq("res_unexpected", 1, 0);
        else begin
          re = res_q.pop_front();
          check_eq("m_name", m_name, re.n);
          check_eq("m_value", m_value, re.v);
        end
        hs_total++;
        last_hs_cyc = cyc;
      end
      if (prev_busy && !cmd_busy) check_eq("busy_fall", cyc - last_hs_cyc, 1);
      if (s_valid && s_ready) wr_q.push_back('{d: s_data, c: cyc + 1});
      prev_mv   = m_valid;
      prev_mr   = m_ready;
      prev_busy = cmd_busy;
      prev_name = m_name;
      prev_val  = m_value;
    end
    prev_sready = s_ready;
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_strobes"}, {knn_wr_en, knn_rd_en, knn_start, knn_done}, 0);
    check_eq({tag, "_knn_data"}, knn_data, 0);
    check_eq({tag, "_m_name"}, m_name, 0);
    check_eq({tag, "_m_value"}, m_value, 0);
    check_eq({tag, "_flags"}, {cmd_busy, s_ready, m_valid}, 0);
  endtask

  task automatic run_job(input int nv, input bit toggle, input int stall_res,
                         input bit go_busy, input bit go_end, input int abort_at,
                         input int base);
    int wr0 = wr_total;
    int st0 = start_total;
    int dn0 = done_total;
    int rd0 = rd_total;
    int hs0 = hs_total;
    int nwords = DIM * (nv + 1);
    int sent = 0;
    int guard = 0;
    int stall = 0;
    bit ph = 1'b1;
    bit hs;
    bit aborted = 1'b0;
    cmd_go = 1'b1;
    cmd_num_vec = 16'(nv);
    @(posedge clk); #1;
    cmd_go = 1'b0;
    cmd_num_vec = '0;
    check_eq("busy_rise", cmd_busy, 1);
    while (sent < nwords && guard < 400 && !aborted) begin
      if (abort_at != 0 && sent == abort_at) begin
        reset = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        aborted = 1'b1;
      end else begin
        s_valid     = toggle ? ph : 1'b1;
        s_data      = 32'(base + sent + 1);
        cmd_go      = go_busy && (sent == 2);
        cmd_num_vec = cmd_go ? 16'd5 : 16'd0;
        @(negedge clk);
        hs = s_valid && s_ready;
        @(posedge clk); #1;
        if (hs) sent++;
        ph = !ph;
        guard++;
      end
    end
    s_valid = 1'b0;
    cmd_go  = 1'b0;
    cmd_num_vec = '0;
    if (guard >= 400) check_eq("feed_timeout", 1, 0);
    if (aborted) begin
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("held_reset");
      reset = 1'b1;
      @(posedge clk); #1;
      check_eq("idle_after_reset", cmd_busy, 0);
    end else begin
      guard = 0;
      while (cmd_busy && guard < 500) begin
        m_ready = 1'b1;
        cmd_go  = 1'b0;
        if (m_valid && stall_res == hs_total - hs0 + 1 && stall < 5) begin
          m_ready = 1'b0;
          stall++;
        end else if (go_end && m_valid && (hs_total - hs0) == KR - 1) begin
          cmd_go = 1'b1;
        end
        @(posedge clk); #1;
        guard++;
      end
      m_ready = 1'b1;
      cmd_go  = 1'b0;
      if (guard >= 500) check_eq("busy_timeout", 1, 0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("idle_after_job", cmd_busy, 0);
      check_eq("start_count", start_total - st0, 1);
      check_eq("done_count", done_total - dn0, 1);
      check_eq("wr_count", wr_total - wr0, nwords);
      check_eq("rd_count", rd_total - rd0, KR);
      check_eq("result_count", hs_total - hs0, KR);
      check_eq("results_drained", res_q.size(), 0);
      if (stall_res != 0) check_eq("stall_cycles", stall, 5);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    run_job(2, 1'b0, 0, 1'b0, 1'b0, 0, 0);    // data 1..12, first result 7 / 0x20
    run_job(0, 1'b0, 0, 1'b0, 1'b0, 0, 20);   // no training vectors
    run_job(1, 1'b0, 2, 1'b0, 1'b1, 0, 40);   // stall result 2, cmd_go on final handshake
    run_job(2, 1'b1, 0, 1'b1, 1'b0, 0, 60);   // s_valid toggling, cmd_go while busy
    run_job(3, 1'b0, 0, 1'b0, 1'b0, 8, 80);   // reset at training word 5
    run_job(2, 1'b0, 0, 1'b0, 1'b0, 0, 100);  // full job after reset
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
